// File: rtl/frodo_pkg.sv
// frodo_pkg: opcode encodings, instruction field offsets and matrix index width shared by the dispatch slice
package frodo_pkg;
  localparam int IDX_W = 4;
  localparam int OPC_W = 3;
  // field offsets measured from the top of the addr field: {opcode, A, B, C, addr}
  localparam int C_OFF = 0;
  localparam int B_OFF = 4;
  localparam int A_OFF = 8;
  localparam int OPC_OFF = 12;
  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 3'd0, OP_1 = 3'd1, OP_2 = 3'd2, OP_3 = 3'd3,
    OP_4 = 3'd4, OP_5 = 3'd5, OP_6 = 3'd6, OP_FENCE = 3'd7
  } opcode_t;
  function automatic logic is_exec(opcode_t op);
    return op != OP_NOP && op != OP_FENCE;
  endfunction
endpackage

// File: rtl/inst_dispatch_if.sv
// inst_dispatch_if: instruction input, issue output and completion handshakes of the dispatcher
interface inst_dispatch_if import frodo_pkg::*; #(parameter int INST_WIDTH = 27) ();
  logic [INST_WIDTH-1:0] inst;
  logic [INST_WIDTH-1:0] issue_inst;
  logic inst_valid;
  logic inst_ready;
  logic issue_valid;
  logic issue_ready;
  logic done_valid;
  logic [IDX_W-1:0] done_idx;
  logic idle;
  modport master(output inst, inst_valid, issue_ready, done_valid, done_idx,
                 input inst_ready, issue_inst, issue_valid, idle);
  modport slave(input inst, inst_valid, issue_ready, done_valid, done_idx,
                output inst_ready, issue_inst, issue_valid, idle);
endinterface

// File: rtl/inst_fifo.sv
// inst_fifo: in-order instruction queue with registered occupancy count and wrapping pointers
module inst_fifo #(
  parameter int W = 27,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign dout = mem[rp];
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
endmodule

// File: rtl/inst_dispatch.sv
// inst_dispatch: queues instructions and issues them in order behind a 16-entry busy scoreboard
// DISPATCH_PERF_EN adds saturating stall_cnt/issue_cnt outputs
module inst_dispatch import frodo_pkg::*; #(
  parameter int INST_WIDTH = 27,
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rstn,
  inst_dispatch_if.slave bus
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] issue_cnt
`endif
);
  logic [INST_WIDTH-1:0] head;
  logic empty, full, push, pop, fire, hazard, exec;
  logic [15:0] busy;
  logic [IDX_W-1:0] a, b, c;
  opcode_t op;
  inst_fifo #(.W(INST_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rstn(rstn), .push(push), .pop(pop), .din(bus.inst),
    .dout(head), .empty(empty), .full(full)
  );
  assign op = opcode_t'(head[ADDR_WIDTH+OPC_OFF +: OPC_W]);
  assign a = head[ADDR_WIDTH+A_OFF +: IDX_W];
  assign b = head[ADDR_WIDTH+B_OFF +: IDX_W];
  assign c = head[ADDR_WIDTH+C_OFF +: IDX_W];
  // hazard sees the pre-update scoreboard, so a same-cycle done never unblocks early
  assign hazard = busy[a] | busy[b] | busy[c];
  assign exec = !empty && is_exec(op);
  assign bus.issue_valid = exec && !hazard;
  assign bus.issue_inst = head;
  assign fire = bus.issue_valid && bus.issue_ready;
  assign pop = fire || (!empty && (op == OP_NOP || (op == OP_FENCE && busy == '0)));
  assign bus.inst_ready = rstn && !full;
  assign push = bus.inst_valid && bus.inst_ready;
  assign bus.idle = empty && busy == '0;
  // set after clear so an issue wins over a same-cycle done on the same index
  always_ff @(posedge clk)
    if (!rstn) busy <= '0;
    else busy <= (busy & ~(16'(bus.done_valid) << bus.done_idx)) | (16'(fire) << c);
`ifdef DISPATCH_PERF_EN
  always_ff @(posedge clk)
    if (!rstn) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if (exec && hazard && ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
      if (fire && ~&issue_cnt) issue_cnt <= issue_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_inst_dispatch.sv
// tb_inst_dispatch: directed and random stimulus checked cycle by cycle against a queue-based reference model
module tb_inst_dispatch;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [26:0] q[$];
  logic [15:0] mbusy = '0;
  logic [31:0] mstall = '0, missue = '0;
  inst_dispatch_if #(.INST_WIDTH(27)) bus ();
`ifdef DISPATCH_PERF_EN
  logic [31:0] stall_cnt, issue_cnt;
`endif
  inst_dispatch #(.INST_WIDTH(27), .ADDR_WIDTH(12), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
`ifdef DISPATCH_PERF_EN
    , .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
`endif
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [26:0] mk(input int op, input int a, input int b, input int c);
    return {3'(op), 4'(a), 4'(b), 4'(c), 12'($urandom_range(4095))};
  endfunction

  // one clock: drive, compare against the model's view of this cycle, then advance the model
  task automatic step(input logic r, input logic iv, input logic [26:0] in, input logic ir,
                      input logic dv, input logic [3:0] di);
    logic [26:0] h;
    logic [2:0] op;
    logic haz, ev, fire, pop, push;
    @(negedge clk);
    rstn = r;
    bus.inst_valid = iv;
    bus.inst = in;
    bus.issue_ready = ir;
    bus.done_valid = dv;
    bus.done_idx = di;
    #1;
    h = q.size() > 0 ? q[0] : '0;
    op = h[26:24];
    haz = mbusy[h[23:20]] | mbusy[h[19:16]] | mbusy[h[15:12]];
    ev = q.size() > 0 && op >= 3'd1 && op <= 3'd6 && !haz;
    chk("inst_ready", 32'(bus.inst_ready), 32'(r && q.size() < 4));
    chk("issue_valid", 32'(bus.issue_valid), 32'(ev));
    if (ev) chk("issue_inst", 32'(bus.issue_inst), 32'(h));
    chk("idle", 32'(bus.idle), 32'(q.size() == 0 && mbusy == 0));
    chk("busy", 32'(dut.busy), 32'(mbusy));
`ifdef DISPATCH_PERF_EN
    chk("stall_cnt", stall_cnt, mstall);
    chk("issue_cnt", issue_cnt, missue);
`endif
    if (!r) begin
      q.delete();
      mbusy = '0;
      mstall = '0;
      missue = '0;
    end else begin
      fire = ev && ir;
      pop = fire || (q.size() > 0 && (op == 3'd0 || (op == 3'd7 && mbusy == 0)));
      push = iv && q.size() < 4;
      if (q.size() > 0 && op >= 3'd1 && op <= 3'd6 && haz && mstall != 32'hFFFF_FFFF) mstall++;
      if (fire && missue != 32'hFFFF_FFFF) missue++;
      if (dv) mbusy[di] = 1'b0;
      if (fire) mbusy[h[15:12]] = 1'b1;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(in);
    end
  endtask

  task automatic nop_step(input logic ir);
    step(1'b1, 1'b0, '0, ir, 1'b0, 4'd0);
  endtask

  task automatic after_edge;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] di;
    bus.inst = '0;
    bus.inst_valid = 1'b0;
    bus.issue_ready = 1'b0;
    bus.done_valid = 1'b0;
    bus.done_idx = '0;
    repeat (3) @(posedge clk);
    repeat (5) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 4'd0);
    // single op reaches issue one cycle after acceptance
    step(1'b1, 1'b1, mk(1, 1, 2, 3), 1'b0, 1'b0, 4'd0);
    after_edge();
    chk("r30_valid", 32'(bus.issue_valid), 32'd1);
    nop_step(1'b1);
    after_edge();
    chk("r30_busy3", 32'(dut.busy[3]), 32'd1);
    // RAW on index 3 holds the second op until done
    step(1'b1, 1'b1, mk(2, 3, 4, 5), 1'b1, 1'b0, 4'd0);
    after_edge();
    chk("r31_held", 32'(bus.issue_valid), 32'd0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, 4'd3);
    after_edge();
    chk("r31_release", 32'(bus.issue_valid), 32'd1);
    nop_step(1'b1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1, 4'd5);
    // fill the queue with issue blocked
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, mk(1, 8, 9, 10), 1'b0, 1'b0, 4'd0);
    after_edge();
    chk("r32_full", 32'(bus.inst_ready), 32'd0);
    step(1'b1, 1'b1, mk(1, 8, 9, 10), 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b1, mk(1, 8, 9, 10), 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, mk(1, 8, 9, 10), 1'b0, 1'b0, 4'd0);
    repeat (14) step(1'b1, 1'b0, '0, 1'b1, 1'b1, 4'd10);
    nop_step(1'b0);
    // done on a clear index in the same cycle as an issue writing it
    step(1'b1, 1'b1, mk(1, 0, 1, 3), 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, 4'd3);
    after_edge();
    chk("r34_set_wins", 32'(dut.busy[3]), 32'd1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1, 4'd3);
    // NOP drains immediately, FENCE waits for the scoreboard
    step(1'b1, 1'b1, mk(1, 0, 0, 7), 1'b1, 1'b0, 4'd0);
    nop_step(1'b1);
    step(1'b1, 1'b1, mk(0, 0, 0, 0), 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b1, mk(7, 0, 0, 0), 1'b0, 1'b0, 4'd0);
    repeat (3) nop_step(1'b0);
    after_edge();
    chk("r33_fence_held", 32'(bus.idle), 32'd0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1, 4'd7);
    nop_step(1'b0);
    after_edge();
    chk("r33_idle", 32'(bus.idle), 32'd1);
    // reset mid-operation drops queue and scoreboard
    step(1'b1, 1'b1, mk(1, 0, 0, 2), 1'b1, 1'b0, 4'd0);
    nop_step(1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, mk(3, 2, 4, 6), 1'b1, 1'b0, 4'd0);
    repeat (2) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 4'd0);
    nop_step(1'b0);
    chk("r35_idle", 32'(bus.idle), 32'd1);
    chk("r35_valid", 32'(bus.issue_valid), 32'd0);
`ifdef DISPATCH_PERF_EN
    chk("r35_stall0", stall_cnt, 32'd0);
    chk("r35_issue0", issue_cnt, 32'd0);
`endif
    for (int n = 0; n < 3000; n++) begin
      di = 4'($urandom_range(15));
      if (mbusy != 0 && $urandom_range(3) != 0)
        repeat (16) if (!mbusy[di]) di = di + 4'd1;
      step($urandom_range(199) != 0, $urandom_range(2) != 0,
           mk($urandom_range(7), $urandom_range(15), $urandom_range(15), $urandom_range(15)),
           $urandom_range(3) != 0, $urandom_range(1) != 0, di);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/inst_dispatch.md
INST_DISPATCH -- requirements
Module: inst_dispatch

Interface
REQ-001 SHALL have parameter INST_WIDTH, default 27, instruction width {opcode[26:24], A_index[23:20], B_index[19:16], C_index[15:12], addr[11:0]}.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, width of the address/immediate field.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 inst  input  INST_WIDTH  incoming instruction.
REQ-007 inst_valid  input  1  inst present this cycle.
REQ-008 inst_ready  output  1  queue can accept; transfer when inst_valid && inst_ready.
REQ-009 issue_inst  output  INST_WIDTH  instruction presented to the matrix execution unit.
REQ-010 issue_valid  output  1  issue_inst valid.
REQ-011 issue_ready  input  1  execution unit accepts; issue fires when issue_valid && issue_ready.
REQ-012 done_valid  input  1  execution unit completed one instruction this cycle.
REQ-013 done_idx  input  4  C_index of the completed instruction.
REQ-014 idle  output  1  queue empty, no issue pending, scoreboard clear.

Function
REQ-015 SHALL buffer accepted instructions in an in-order FIFO of FIFO_DEPTH; inst_ready = !full (registered-count based, no combinational path from issue_ready).
REQ-016 SHALL keep a 16-bit busy scoreboard, one bit per matrix index; bit C_index set on issue fire, cleared on done_valid for done_idx.
REQ-017 SHALL assert issue_valid for the FIFO head only when opcode is 1..6 and busy[A], busy[B], busy[C] are all clear (RAW/WAW/WAR stall); head stays put while stalled.
REQ-018 opcode 3'b000 (NOP) SHALL be popped in one cycle without asserting issue_valid or touching the scoreboard.
REQ-019 opcode 3'b111 (FENCE) SHALL be held at head until scoreboard is all-zero, then popped without issue.
REQ-020 issue_valid, once asserted, SHALL hold with issue_inst stable until fire.
REQ-021 Minimum latency: instruction accepted in cycle N SHALL appear on issue_valid in cycle N+1 if FIFO was empty and no hazard.
REQ-022 Simultaneous push and pop on a full FIFO SHALL NOT be accepted (inst_ready low when full); push and pop on non-full SHALL keep count unchanged.
REQ-023 Same-cycle done_valid clearing bit X and issue setting bit X SHALL leave bit X set (set wins); hazard check uses pre-update scoreboard.
REQ-024 done_valid for a non-busy index SHALL be ignored.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-026 With rstn low at a rising edge: FIFO empty, pointers 0, scoreboard 0, issue_valid 0, inst_ready 0 during reset then 1 the first cycle after, idle 1; reset mid-operation discards all queued and in-flight state.

Configuration
REQ-027 With DISPATCH_PERF_EN defined, SHALL add outputs stall_cnt[31:0] (cycles head is valid non-NOP/FENCE but blocked by hazard) and issue_cnt[31:0] (issue fires), both saturating, cleared by reset; without it, neither port nor counters exist.

Structure
REQ-028 Opcode encodings (NOP, FENCE, ops 1..6), field bit positions and index width SHALL live in shared package frodo_pkg.
REQ-029 FIFO SHALL be a separate sub-module inst_fifo; scoreboard and issue logic in inst_dispatch.

Verification
REQ-030 Reset 5 cycles, push op1 A=1,B=2,C=3 -> issue_valid next cycle, fires with issue_ready=1, busy[3]=1.
REQ-031 Push op1 C=3 then op2 A=3,B=4,C=5 with no done -> second held; done_valid idx=3 -> second issues the following cycle.
REQ-032 Push 5 instructions with issue_ready=0 -> inst_ready low after 4 accepted; 5th held until a pop.
REQ-033 Push NOP then FENCE with busy[7]=1 -> NOP popped in 1 cycle, FENCE held until done_idx=7, idle=1 next cycle.
REQ-034 Same-cycle done_idx=3 and issue with C=3 -> busy[3] remains 1.
REQ-035 Reset asserted with 3 queued and busy[2]=1 -> after release idle=1, issue_valid=0; with DISPATCH_PERF_EN, counters read 0.
